// File: rtl/dmem_block_mover.sv
// Memory-port initiator that performs block copy (memory->memory) or block fill
// (constant->memory) on the 2**AW x DW data memory while the CPU is held off the port.
module dmem_block_mover #(
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [CW-1:0] length,
    input  logic [DW-1:0] fill_val,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] D_Addr,
    output logic          D_wr,
    output logic [DW-1:0] W_data,
    input  logic [DW-1:0] R_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_FILL = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] LEN_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] LEN_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

    state_t        state_r;
    state_t        state_s;
    logic [AW-1:0] src_ptr_r;
    logic [AW-1:0] dst_ptr_r;
    logic [CW-1:0] remain_r;
    logic          desc_r;
    logic [DW-1:0] fill_r;
    logic [DW-1:0] hold_r;
    logic [CW-1:0] src_end_s;
    logic          desc_s;

    // Pointer advance; all address arithmetic wraps modulo the memory depth.
    function automatic logic [AW-1:0] step_ptr(input logic [AW-1:0] ptr, input logic down);
        if (down) begin
            step_ptr = ptr - PTR_ONE;
        end else begin
            step_ptr = ptr + PTR_ONE;
        end
    endfunction

    // A descending walk begins at the last word of the block, an ascending one at its base.
    function automatic logic [AW-1:0] first_ptr(input logic [AW-1:0] base,
                                                input logic [CW-1:0] len,
                                                input logic          down);
        if (down) begin
            first_ptr = base + len[AW-1:0] - PTR_ONE;
        end else begin
            first_ptr = base;
        end
    endfunction

    // Copy direction: walk backwards when the destination overlaps the tail of the source.
    always_comb begin
        src_end_s = CW'(src_addr) + length;
        desc_s    = 1'b0;
        if (!mode && (dst_addr > src_addr) && (CW'(dst_addr) < src_end_s)) begin
            desc_s = 1'b1;
        end else begin
            desc_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!start) begin
                    state_s = S_IDLE;
                end else if (length == LEN_ZERO) begin
                    state_s = S_FIN;
                end else if (mode) begin
                    state_s = S_FILL;
                end else begin
                    state_s = S_RD;
                end
            end
            S_RD: begin
                state_s = S_WR;
            end
            S_WR: begin
                if (remain_r == LEN_ONE) begin
                    state_s = S_FIN;
                end else begin
                    state_s = S_RD;
                end
            end
            S_FILL: begin
                if (remain_r == LEN_ONE) begin
                    state_s = S_FIN;
                end else begin
                    state_s = S_FILL;
                end
            end
            S_FIN: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Transfer datapath: arguments latch only on an accepted start, pointers step per access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ptr_r <= PTR_ZERO;
            dst_ptr_r <= PTR_ZERO;
            remain_r  <= LEN_ZERO;
            desc_r    <= 1'b0;
            fill_r    <= DATA_ZERO;
            hold_r    <= DATA_ZERO;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        src_ptr_r <= first_ptr(src_addr, length, desc_s);
                        dst_ptr_r <= first_ptr(dst_addr, length, desc_s);
                        remain_r  <= length;
                        desc_r    <= desc_s;
                        fill_r    <= fill_val;
                    end
                end
                S_RD: begin
                    hold_r    <= R_data;
                    src_ptr_r <= step_ptr(src_ptr_r, desc_r);
                end
                S_WR, S_FILL: begin
                    dst_ptr_r <= step_ptr(dst_ptr_r, desc_r);
                    remain_r  <= remain_r - LEN_ONE;
                end
                default: begin
                    hold_r <= hold_r;
                end
            endcase
        end
    end

    // Memory-port and status outputs decode purely from registered state, so reset clears them at once.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        D_wr   = 1'b0;
        D_Addr = PTR_ZERO;
        W_data = DATA_ZERO;
        case (state_r)
            S_RD: begin
                busy   = 1'b1;
                D_Addr = src_ptr_r;
            end
            S_WR: begin
                busy   = 1'b1;
                D_wr   = 1'b1;
                D_Addr = dst_ptr_r;
                W_data = hold_r;
            end
            S_FILL: begin
                busy   = 1'b1;
                D_wr   = 1'b1;
                D_Addr = dst_ptr_r;
                W_data = fill_r;
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_block_mover.sv
// Randomized bench for dmem_block_mover: a per-cycle expected-trace model built from
// word-by-word copy/fill semantics, plus literal checks on the directed scenarios.
module tb_dmem_block_mover;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [7:0]  src_addr;
    logic [7:0]  dst_addr;
    logic [8:0]  length;
    logic [15:0] fill_val;
    logic        busy;
    logic        done;
    logic [7:0]  D_Addr;
    logic        D_wr;
    logic [15:0] W_data;
    logic [15:0] R_data;

    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];

    typedef struct {
        bit busy;
        bit done;
        bit wr;
        int addr;
        int wdata;
    } rec_t;

    rec_t exp_q[$];
    int   wlog[$];
    int   wdat[$];

    int checks = 0;
    int errors = 0;
    bit pre_en = 1'b0;
    int pre_addr = 0;
    int pre_data = 0;
    bit pend_wr = 1'b0;
    int pend_addr = 0;
    int pend_data = 0;
    int busy_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    dmem_block_mover dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .fill_val (fill_val),
        .busy     (busy),
        .done     (done),
        .D_Addr   (D_Addr),
        .D_wr     (D_wr),
        .W_data   (W_data),
        .R_data   (R_data)
    );

    assign R_data = mem[D_Addr];

    always #5 clk = ~clk;

    // Memory model plus observation counters and the write log.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr[7:0]]     <= pre_data[15:0];
            ref_mem[pre_addr[7:0]] <= pre_data[15:0];
        end
        if (D_wr) begin
            mem[D_Addr] <= W_data;
            wr_cnt      <= wr_cnt + 1;
            wlog.push_back(int'(D_Addr));
            wdat.push_back(int'(W_data));
        end
        if (pend_wr) ref_mem[pend_addr[7:0]] <= pend_data[15:0];
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the expected trace; an empty trace means idle.
    always @(negedge clk) begin
        rec_t r;
        r = '{busy: 1'b0, done: 1'b0, wr: 1'b0, addr: 0, wdata: 0};
        if (exp_q.size() > 0) r = exp_q.pop_front();
        chk("busy",   int'(busy),   int'(r.busy));
        chk("done",   int'(done),   int'(r.done));
        chk("d_wr",   int'(D_wr),   int'(r.wr));
        chk("d_addr", int'(D_Addr), r.addr);
        chk("w_data", int'(W_data), r.wdata);
        pend_wr   = r.wr;
        pend_addr = r.addr;
        pend_data = r.wdata;
    end

    // Behavioural model: word-by-word copy on a scratch image, emitting the expected cycle trace.
    task automatic model_op(input bit m, input int s, input int d, input int n, input int f);
        logic [15:0] sc [256];
        bit desc;
        int idx, ra, wa;
        for (int i = 0; i < 256; i++) sc[i] = ref_mem[i];
        if (n > 0) begin
            if (m) begin
                for (int i = 0; i < n; i++)
                    exp_q.push_back('{busy: 1'b1, done: 1'b0, wr: 1'b1, addr: (d + i) % 256, wdata: f});
            end else begin
                desc = (d > s) && (d < s + n);
                for (int i = 0; i < n; i++) begin
                    idx = desc ? (n - 1 - i) : i;
                    ra  = (s + idx) % 256;
                    wa  = (d + idx) % 256;
                    exp_q.push_back('{busy: 1'b1, done: 1'b0, wr: 1'b0, addr: ra, wdata: 0});
                    exp_q.push_back('{busy: 1'b1, done: 1'b0, wr: 1'b1, addr: wa, wdata: int'(sc[ra])});
                    sc[wa] = sc[ra];
                end
            end
        end
        exp_q.push_back('{busy: 1'b0, done: 1'b1, wr: 1'b0, addr: 0, wdata: 0});
    endtask

    task automatic preset(input int a, input int v);
        pre_addr = a;
        pre_data = v;
        pre_en   = 1'b1;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic scramble();
        mode     = 1'($urandom_range(0, 1));
        src_addr = 8'($urandom);
        dst_addr = 8'($urandom);
        length   = 9'($urandom_range(0, 256));
        fill_val = 16'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic mem_compare(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk(name, bad, 0);
    endtask

    // One request; glitch >= 0 pulses start with new arguments that many cycles into the run.
    task automatic run_op(input bit m, input int s, input int d, input int n, input int f, input int glitch);
        #2;
        mode     = m;
        src_addr = s[7:0];
        dst_addr = d[7:0];
        length   = n[8:0];
        fill_val = f[15:0];
        start    = 1'b1;
        @(posedge clk);
        #1;
        model_op(m, s, d, n, f);
        start = 1'b0;
        scramble();
        if (glitch >= 0) begin
            repeat (glitch) @(posedge clk);
            #2;
            scramble();
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        wait_drain();
        #1;
        mem_compare("mem_image");
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_busy, b_wr, b_done, b_log;
        int s, d, n, m, r_len, g;
        rst_n = 1'b0;
        start = 1'b0;
        mode = 1'b0;
        src_addr = 8'h00;
        dst_addr = 8'h00;
        length = 9'h000;
        fill_val = 16'h0000;
        #1;
        chk("rst_busy",   int'(busy),   0);
        chk("rst_done",   int'(done),   0);
        chk("rst_d_wr",   int'(D_wr),   0);
        chk("rst_d_addr", int'(D_Addr), 0);
        chk("rst_w_data", int'(W_data), 0);
        for (int i = 0; i < 256; i++) preset(i, int'($urandom_range(0, 65535)));
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Plain ascending copy.
        preset('h10, 'h1111); preset('h11, 'h2222); preset('h12, 'h3333); preset('h13, 'h4444);
        for (int i = 0; i < 4; i++) preset('h20 + i, 0);
        b_busy = busy_cnt; b_wr = wr_cnt; b_done = done_cnt; b_log = wlog.size();
        run_op(1'b0, 'h10, 'h20, 4, 0, -1);
        chk("copy_d0", int'(mem[8'h20]), 'h1111);
        chk("copy_d1", int'(mem[8'h21]), 'h2222);
        chk("copy_d2", int'(mem[8'h22]), 'h3333);
        chk("copy_d3", int'(mem[8'h23]), 'h4444);
        chk("copy_src3", int'(mem[8'h13]), 'h4444);
        chk("copy_busy_cycles", busy_cnt - b_busy, 8);
        chk("copy_writes", wr_cnt - b_wr, 4);
        chk("copy_dones", done_cnt - b_done, 1);
        chk("copy_order0", wlog[b_log], 'h20);
        chk("copy_order3", wlog[b_log + 3], 'h23);

        // Overlapping copy must run descending.
        for (int i = 0; i < 4; i++) preset('h40 + i, i + 1);
        preset('h44, 0);
        b_log = wlog.size();
        run_op(1'b0, 'h40, 'h41, 4, 0, -1);
        chk("ovl_order0", wlog[b_log], 'h44);
        chk("ovl_order1", wlog[b_log + 1], 'h43);
        chk("ovl_order3", wlog[b_log + 3], 'h41);
        chk("ovl_m40", int'(mem[8'h40]), 1);
        chk("ovl_m41", int'(mem[8'h41]), 1);
        chk("ovl_m42", int'(mem[8'h42]), 2);
        chk("ovl_m44", int'(mem[8'h44]), 4);

        // Fill that wraps past the top of memory.
        preset('h02, 'h1234);
        b_busy = busy_cnt; b_log = wlog.size();
        run_op(1'b1, 0, 'hFE, 4, 'hBEEF, -1);
        chk("fill_a0", wlog[b_log], 'hFE);
        chk("fill_a2", wlog[b_log + 2], 'h00);
        chk("fill_a3", wlog[b_log + 3], 'h01);
        chk("fill_d3", wdat[b_log + 3], 'hBEEF);
        chk("fill_m02", int'(mem[8'h02]), 'h1234);
        chk("fill_busy_cycles", busy_cnt - b_busy, 4);

        // Zero length, with start still high during the FIN cycle.
        b_busy = busy_cnt; b_wr = wr_cnt; b_done = done_cnt;
        run_op(1'b0, 'h10, 'h30, 0, 0, 0);
        chk("zero_dones", done_cnt - b_done, 1);
        chk("zero_busy", busy_cnt - b_busy, 0);
        chk("zero_writes", wr_cnt - b_wr, 0);

        // New start while busy is dropped.
        b_wr = wr_cnt; b_done = done_cnt; b_busy = busy_cnt;
        run_op(1'b0, 'h50, 'hA0, 6, 0, 3);
        chk("busy_start_dones", done_cnt - b_done, 1);
        chk("busy_start_writes", wr_cnt - b_wr, 6);
        chk("busy_start_cycles", busy_cnt - b_busy, 12);

        // Reset during the third write.
        for (int i = 0; i < 8; i++) begin
            preset('h60 + i, 'h1000 + i);
            preset('h70 + i, 'h5555);
        end
        b_done = done_cnt;
        #2;
        mode = 1'b0; src_addr = 8'h60; dst_addr = 8'h70; length = 9'd8; fill_val = 16'h0000;
        start = 1'b1;
        @(posedge clk);
        #1;
        model_op(1'b0, 'h60, 'h70, 8, 0);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_mid_wr_before", int'(D_wr), 1);
        chk("rst_mid_addr_before", int'(D_Addr), 'h72);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_wr_after", int'(D_wr), 0);
        chk("rst_mid_busy_after", int'(busy), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_m70", int'(mem[8'h70]), 'h1000);
        chk("rst_mid_m71", int'(mem[8'h71]), 'h1001);
        chk("rst_mid_m72", int'(mem[8'h72]), 'h5555);
        chk("rst_mid_dones", done_cnt - b_done, 0);
        mem_compare("rst_mid_image");
        run_op(1'b0, 'h60, 'h70, 8, 0, -1);
        chk("post_rst_m77", int'(mem[8'h77]), 'h1007);

        // Whole-memory fill and copy.
        run_op(1'b1, 0, 'h80, 256, 'h5A5A, -1);
        chk("full_fill_m7f", int'(mem[8'h7F]), 'h5A5A);
        for (int i = 0; i < 256; i += 7) preset(i, int'($urandom_range(0, 65535)));
        run_op(1'b0, 'h30, 'h90, 256, 0, -1);

        // Random requests, overlap-biased, occasionally hit by a stray start.
        for (int k = 0; k < 40; k++) begin
            m = int'($urandom_range(0, 1));
            s = int'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) d = (s + int'($urandom_range(0, 8)) + 252) % 256;
            else d = int'($urandom_range(0, 255));
            case ($urandom_range(0, 19))
                0: n = 0;
                1: n = 256;
                2: n = 1;
                default: n = int'($urandom_range(2, 24));
            endcase
            if (n == 0) r_len = 1;
            else if (m == 1) r_len = n + 1;
            else r_len = 2 * n + 1;
            if ($urandom_range(0, 1) == 1) g = int'($urandom_range(0, r_len - 1));
            else g = -1;
            run_op(m[0], s, d, n, int'($urandom_range(0, 65535)), g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
